// File: rtl/toaster_pkg.sv
// Shared types and helpers for the toaster cycle sequencer: state encoding,
// limits, and the BCD M:SS conversions used by the countdown display.
package toaster_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int PWM_STEPS = 100;
  localparam int MAX_SECS  = 599;

  // M:SS BCD decrement; ones borrow from tens, tens (0->5) borrow from minutes.
  function automatic logic [11:0] bcd_dec(input logic [11:0] v);
    logic [3:0] m;
    logic [3:0] t;
    logic [3:0] s;
    {m, t, s} = v;
    if (s != 4'd0) begin
      s = s - 4'd1;
    end else begin
      s = 4'd9;
      if (t != 4'd0) begin
        t = t - 4'd1;
      end else begin
        t = 4'd5;
        m = m - 4'd1;
      end
    end
    return {m, t, s};
  endfunction

  // Binary seconds -> M:SS BCD, saturated to 9:59.
  function automatic logic [11:0] secs_to_bcd(input logic [9:0] secs);
    logic [9:0] sat;
    logic [9:0] mins;
    logic [9:0] rem;
    sat  = (secs > 10'(MAX_SECS)) ? 10'(MAX_SECS) : secs;
    mins = sat / 10'd60;
    rem  = sat % 10'd60;
    return {mins[3:0], 4'(rem / 10'd10), 4'(rem % 10'd10)};
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// 100-step PWM for the heating element; the output is registered and is
// computed from post-edge counter values so it lines up with the FSM state.
module pwm_gen #(
  parameter int PWM_DIV   = 5_000,
  parameter int PWM_STEPS = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [6:0] duty,
  output logic       pwm
);

  localparam int DW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_nxt;
  logic [6:0]    r_step;
  logic [6:0]    w_step_nxt;
  logic          r_pwm;
  logic          w_pwm_nxt;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_div_nxt  = r_div;
    w_step_nxt = r_step;
    if (clr) begin
      w_div_nxt  = '0;
      w_step_nxt = '0;
    end else if (en) begin
      if (r_div == DW'(PWM_DIV - 1)) begin
        w_div_nxt  = '0;
        w_step_nxt = (r_step == 7'(PWM_STEPS - 1)) ? 7'd0 : r_step + 7'd1;
      end else begin
        w_div_nxt = r_div + DW'(1);
      end
    end
    w_pwm_nxt = en && (w_step_nxt < duty);
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      r_div  <= '0;
      r_step <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_step <= w_step_nxt;
      r_pwm  <= w_pwm_nxt;
    end
  end

  assign pwm = r_pwm;

endmodule

// File: rtl/toast_sequencer.sv
// Toasting-cycle sequencer: write/ack settings latch, 1 s prescaler, BCD
// countdown, IDLE/HEAT/DONE FSM and the heater PWM instance.
module toast_sequencer
  import toaster_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int PWM_DIV   = 5_000,
  parameter int DONE_SECS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        write,
  input  logic [9:0]  Time,
  input  logic [7:0]  DC,
  output logic        write_ack,
  output logic [11:0] tLED,
  output logic        heat,
  output logic        busy,
  output logic        done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DONE_SECS + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [11:0]   r_tled;
  logic [11:0]   w_tled_nxt;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre_nxt;
  logic [CW-1:0] r_done_cnt;
  logic [CW-1:0] w_done_cnt_nxt;
  logic [6:0]    r_duty;
  logic [6:0]    w_duty_nxt;
  logic          r_write_ack;
  logic          r_wr_seen;
  logic          w_wr_acc;
  logic          w_load;
  logic          w_tick;
  logic [11:0]   w_dec;

  // write is acked once per high phase; r_wr_seen re-arms only after a low sample.
  assign w_wr_acc = write && !r_wr_seen;
  assign w_load   = w_wr_acc && start && !stop && (r_state != HEAT);
  assign w_tick   = (r_pre == PW'(TICK_DIV - 1));
  assign w_dec    = bcd_dec(r_tled);

  always_comb begin
    w_state_nxt    = r_state;
    w_tled_nxt     = r_tled;
    w_pre_nxt      = r_pre;
    w_done_cnt_nxt = r_done_cnt;
    w_duty_nxt     = r_duty;

    if (r_state != IDLE) begin
      w_pre_nxt = w_tick ? '0 : r_pre + PW'(1);
    end

    unique case (r_state)
      HEAT: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (w_tick) begin
          w_tled_nxt = w_dec;
          if (w_dec == 12'h000) begin
            w_state_nxt    = DONE;
            w_done_cnt_nxt = '0;
          end
        end
      end
      DONE: begin
        if (stop) begin
          w_state_nxt = IDLE;
        end else if (!w_load && w_tick) begin
          if (r_done_cnt == CW'(DONE_SECS - 1)) begin
            w_state_nxt    = IDLE;
            w_done_cnt_nxt = '0;
          end else begin
            w_done_cnt_nxt = r_done_cnt + CW'(1);
          end
        end
      end
      default: ;
    endcase

    // A load beats a same-edge tick; stop is already excluded from w_load.
    if (w_load) begin
      w_tled_nxt     = secs_to_bcd(Time);
      w_duty_nxt     = (DC > 8'd100) ? 7'd100 : DC[6:0];
      w_pre_nxt      = '0;
      w_done_cnt_nxt = '0;
      w_state_nxt    = (Time == 10'd0) ? DONE : HEAT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tled      <= 12'h000;
      r_pre       <= '0;
      r_done_cnt  <= '0;
      r_duty      <= '0;
      r_write_ack <= 1'b0;
      r_wr_seen   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tled      <= w_tled_nxt;
      r_pre       <= w_pre_nxt;
      r_done_cnt  <= w_done_cnt_nxt;
      r_duty      <= w_duty_nxt;
      r_write_ack <= w_wr_acc;
      r_wr_seen   <= write;
    end
  end

  // Fed with next-state values so the registered heat output tracks r_state exactly.
  pwm_gen #(
    .PWM_DIV  (PWM_DIV),
    .PWM_STEPS(PWM_STEPS)
  ) u_pwm (
    .clk  (clk),
    .reset(reset),
    .clr  (w_load),
    .en   (w_state_nxt == HEAT),
    .duty (w_duty_nxt),
    .pwm  (heat)
  );

  assign write_ack = r_write_ack;
  assign tLED      = r_tled;
  assign busy      = (r_state == HEAT);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_toast_sequencer.sv
// Directed bench for toast_sequencer with short tick/PWM periods: a load
// table plus hand-written countdown, PWM, stop, handshake and reset sequences.
module tb_toast_sequencer;

  localparam int TICK_DIV  = 10;
  localparam int PWM_DIV   = 2;
  localparam int DONE_SECS = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        write;
  logic [9:0]  Time;
  logic [7:0]  DC;
  logic        write_ack;
  logic [11:0] tLED;
  logic        heat;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  toast_sequencer #(
    .TICK_DIV (TICK_DIV),
    .PWM_DIV  (PWM_DIV),
    .DONE_SECS(DONE_SECS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .write    (write),
    .Time     (Time),
    .DC       (DC),
    .write_ack(write_ack),
    .tLED     (tLED),
    .heat     (heat),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  t;
    logic [7:0]  dc;
    logic [11:0] tled;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge with write low; returns one negedge later with write low.
  task automatic do_write(input logic st, input logic sp, input logic [9:0] t,
                          input logic [7:0] dc, input string nm);
    start = st;
    stop  = sp;
    Time  = t;
    DC    = dc;
    write = 1'b1;
    @(negedge clk);
    check({nm, " ack"}, write_ack, 1);
    write = 1'b0;
  endtask

  task automatic stop_pulse();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic count_heat(input int n, output int hc);
    hc = 0;
    repeat (n) begin
      if (heat) hc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int hc;
    vecs[0]  = '{t: 10'd75,   dc: 8'd40, tled: 12'h115, busy: 1'b1, done: 1'b0};
    vecs[1]  = '{t: 10'd61,   dc: 8'd10, tled: 12'h101, busy: 1'b1, done: 1'b0};
    vecs[2]  = '{t: 10'd0,    dc: 8'd50, tled: 12'h000, busy: 1'b0, done: 1'b1};
    vecs[3]  = '{t: 10'd700,  dc: 8'd50, tled: 12'h959, busy: 1'b1, done: 1'b0};
    vecs[4]  = '{t: 10'd599,  dc: 8'd50, tled: 12'h959, busy: 1'b1, done: 1'b0};
    vecs[5]  = '{t: 10'd600,  dc: 8'd50, tled: 12'h959, busy: 1'b1, done: 1'b0};
    vecs[6]  = '{t: 10'd60,   dc: 8'd50, tled: 12'h100, busy: 1'b1, done: 1'b0};
    vecs[7]  = '{t: 10'd59,   dc: 8'd50, tled: 12'h059, busy: 1'b1, done: 1'b0};
    vecs[8]  = '{t: 10'd9,    dc: 8'd50, tled: 12'h009, busy: 1'b1, done: 1'b0};
    vecs[9]  = '{t: 10'd1023, dc: 8'd50, tled: 12'h959, busy: 1'b1, done: 1'b0};
    vecs[10] = '{t: 10'd119,  dc: 8'd50, tled: 12'h159, busy: 1'b1, done: 1'b0};
    vecs[11] = '{t: 10'd540,  dc: 8'd50, tled: 12'h900, busy: 1'b1, done: 1'b0};

    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    write = 1'b0;
    Time  = '0;
    DC    = '0;
    #3;
    check("reset tLED", tLED, 12'h000);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset heat", heat, 0);
    check("reset ack", write_ack, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Write held for three cycles with start=0: one ack, no load.
    Time  = 10'd100;
    write = 1'b1;
    @(negedge clk);
    check("hold ack c1", write_ack, 1);
    check("hold no load tLED", tLED, 12'h000);
    check("hold no load busy", busy, 0);
    @(negedge clk);
    check("hold ack c2", write_ack, 0);
    @(negedge clk);
    check("hold ack c3", write_ack, 0);
    write = 1'b0;
    @(negedge clk);

    // Load table: each entry from IDLE.
    for (int i = 0; i < 12; i++) begin
      stop_pulse();
      check($sformatf("vec%0d idle busy", i), busy, 0);
      check($sformatf("vec%0d idle done", i), done, 0);
      do_write(1'b1, 1'b0, vecs[i].t, vecs[i].dc, $sformatf("vec%0d", i));
      check($sformatf("vec%0d tLED", i), tLED, vecs[i].tled);
      check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d done", i), done, vecs[i].done);
    end

    // Time=75, DC=40: 80 of 200 clks high; 20 ticks later tLED=055.
    stop_pulse();
    do_write(1'b1, 1'b0, 10'd75, 8'd40, "t75");
    check("t75 tLED", tLED, 12'h115);
    check("t75 busy", busy, 1);
    @(negedge clk);
    check("t75 ack one cycle", write_ack, 0);
    count_heat(200, hc);
    check("t75 heat count", hc, 80);
    check("t75 tLED after 200", tLED, 12'h055);

    // Time=61: minute borrow at the second tick.
    stop_pulse();
    do_write(1'b1, 1'b0, 10'd61, 8'd10, "t61");
    wait_cyc(9);
    check("t61 tLED 9clk", tLED, 12'h101);
    wait_cyc(1);
    check("t61 tLED 10clk", tLED, 12'h100);
    wait_cyc(10);
    check("t61 tLED 20clk", tLED, 12'h059);

    // Time=3, DC=150: heat solid through HEAT, then DONE for 20 clks.
    stop_pulse();
    do_write(1'b1, 1'b0, 10'd3, 8'd150, "t3");
    check("t3 tLED", tLED, 12'h003);
    hc = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 10) check("t3 tLED 002", tLED, 12'h002);
      if (i == 20) check("t3 tLED 001", tLED, 12'h001);
      if (heat) hc++;
      @(negedge clk);
    end
    check("t3 heat solid", hc, 30);
    check("t3 done tLED", tLED, 12'h000);
    check("t3 done", done, 1);
    check("t3 done busy", busy, 0);
    check("t3 done heat", heat, 0);
    wait_cyc(19);
    check("t3 done last", done, 1);
    wait_cyc(1);
    check("t3 idle done", done, 0);
    check("t3 idle busy", busy, 0);

    // New valid load while in DONE restarts HEAT.
    stop_pulse();
    do_write(1'b1, 1'b0, 10'd0, 8'd50, "t0");
    check("t0 done", done, 1);
    wait_cyc(3);
    do_write(1'b1, 1'b0, 10'd5, 8'd50, "reload");
    check("reload busy", busy, 1);
    check("reload done", done, 0);
    check("reload tLED", tLED, 12'h005);

    // Stop at 042 with a same-cycle write: acked, not loaded.
    stop_pulse();
    do_write(1'b1, 1'b0, 10'd42, 8'd100, "t42");
    check("t42 heat", heat, 1);
    @(negedge clk);
    stop  = 1'b1;
    Time  = 10'd10;
    write = 1'b1;
    @(negedge clk);
    check("stop busy", busy, 0);
    check("stop heat", heat, 0);
    check("stop tLED", tLED, 12'h042);
    check("stop ack", write_ack, 1);
    write = 1'b0;
    @(negedge clk);
    stop = 1'b0;
    do_write(1'b1, 1'b1, 10'd10, 8'd50, "stopload");
    check("stopload tLED", tLED, 12'h042);
    check("stopload busy", busy, 0);
    stop = 1'b0;
    @(negedge clk);
    do_write(1'b0, 1'b0, 10'd10, 8'd50, "nostart");
    check("nostart tLED", tLED, 12'h042);
    check("nostart busy", busy, 0);
    wait_cyc(2);
    check("nostart later tLED", tLED, 12'h042);

    // DC=0: heat never high; a write during HEAT is acked only.
    stop_pulse();
    do_write(1'b1, 1'b0, 10'd20, 8'd0, "dc0");
    count_heat(15, hc);
    check("dc0 heat", hc, 0);
    check("dc0 tLED", tLED, 12'h019);
    do_write(1'b1, 1'b0, 10'd99, 8'd200, "heatwr");
    check("heatwr tLED", tLED, 12'h019);
    check("heatwr busy", busy, 1);
    count_heat(40, hc);
    check("heatwr heat", hc, 0);

    // Asynchronous reset mid-HEAT at tLED=012.
    stop_pulse();
    do_write(1'b1, 1'b0, 10'd12, 8'd100, "t12");
    wait_cyc(2);
    check("t12 tLED", tLED, 12'h012);
    check("t12 heat", heat, 1);
    #2 reset = 1'b1;
    #1;
    check("areset tLED", tLED, 12'h000);
    check("areset busy", busy, 0);
    check("areset heat", heat, 0);
    check("areset done", done, 0);
    check("areset ack", write_ack, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
